seq_detector: RTL and testbench

Serial bit-pattern detector that consumes the sampled bit stream produced by the team's DFF-based input register stage. Shifts one bit per valid strobe into an N-bit window and flags a registered one-cycle `match` whenever the last N accepted bits equal `PATTERN`. Keeps a saturating count of matches for display on the board LEDs/7-seg.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_detector_if.sv | 37 +++
 rtl/seq_detector_sat_counter.sv | 28 ++
 rtl/seq_detector.sv | 108 ++++++++++
 tb/tb_seq_detector.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared constants and types for the serial pattern detector.
//   SEQ_N        default pattern length in bits (legal range 2..16)
//   SEQ_PATTERN  default target sequence; MSB is the oldest bit
//   SEQ_CNT_W    default width of the saturating match counter
//   seq_state_t  detector FSM states: FILL (window not yet full), RUN
package seq_pkg;

   localparam int unsigned           SEQ_N       = 4;
   localparam logic [SEQ_N-1:0]      SEQ_PATTERN = 4'b1011;
   localparam int unsigned           SEQ_CNT_W   = 8;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

   // Bits needed to hold a fill count in the range 0..n.
   function automatic int unsigned fill_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_detector_if.sv
// seq_detector_if: serial stream in, detection status out.
//   din          serial data bit from the upstream register stage
//   din_valid    din is accepted on a rising edge only when high
//   match        registered one-cycle detection pulse
//   match_count  saturating number of detections since reset
//   window       current shift window, for debug/display
// master: the stream source / status consumer. slave: the detector.
interface seq_detector_if
   import seq_pkg::*;
#(
   parameter int unsigned N     = SEQ_N,
   parameter int unsigned CNT_W = SEQ_CNT_W
);

   logic             din;
   logic             din_valid;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic [N-1:0]     window;

   modport master (
      output din,
      output din_valid,
      input  match,
      input  match_count,
      input  window
   );

   modport slave (
      input  din,
      input  din_valid,
      output match,
      output match_count,
      output window
   );

endinterface

// File: rtl/seq_detector_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value instead of wrapping.
//   clk    system clock, rising edge
//   rst    synchronous active-high clear
//   inc    count one event on this edge
//   count  current count (registered)
module sat_counter
   import seq_pkg::*;
#(
   parameter int unsigned CNT_W = SEQ_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Increment unless already at the ceiling.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_detector.sv
// seq_detector: serial bit-pattern detector.
// Shifts din into an N-bit window on every din_valid edge and raises a
// registered one-cycle match when the last N accepted bits equal PATTERN.
// A saturating counter tracks detections since reset.
//   clk   system clock, rising edge
//   rst   synchronous active-high reset (priority over din_valid)
//   bus   seq_detector_if.slave: din, din_valid in; match, match_count,
//         window out
// Build option: define SEQ_OVERLAP_EN for overlapping detection (window and
// RUN state kept after a match). Without it, a match restarts the fill so
// the next detection needs N fresh bits.
module seq_detector
   import seq_pkg::*;
#(
   parameter int unsigned    N       = SEQ_N,
   parameter logic [N-1:0]   PATTERN = N'(SEQ_PATTERN),
   parameter int unsigned    CNT_W   = SEQ_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   seq_detector_if.slave bus
);

   localparam int unsigned        FILL_W    = fill_width(N);
   localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(N - 1);

   seq_state_t         state_q, state_d;
   logic [N-1:0]       window_q, window_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               match_q, match_d;

   logic [N-1:0]       window_shift_c;
   logic               full_next_c;
   logic               hit_c;

   // Candidate window if the current bit is accepted.
   assign window_shift_c = {window_q[N-2:0], bus.din};

   // fill + 1 >= N: the accepted bit completes (or keeps) a full window.
   // This gate also stops the all-zero reset window from ever matching.
   assign full_next_c = (fill_q >= FILL_LAST);

   assign hit_c = bus.din_valid && full_next_c && (window_shift_c == PATTERN);

   // State, window, fill and match registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         window_q <= '0;
         fill_q   <= '0;
         match_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         window_q <= window_d;
         fill_q   <= fill_d;
         match_q  <= match_d;
      end
   end

   // Next-state and match decode.
   always_comb begin
      state_d  = state_q;
      window_d = window_q;
      fill_d   = fill_q;
      match_d  = 1'b0;

      if (bus.din_valid) begin
         window_d = window_shift_c;

         case (state_q)
            FILL: begin
               fill_d = fill_q + FILL_W'(1);
               if (fill_q == FILL_LAST) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               // Window stays full; fill saturates at N.
               fill_d = fill_q;
            end
         endcase

         if (hit_c) begin
            match_d = 1'b1;
`ifndef SEQ_OVERLAP_EN
            // Non-overlapping: window bits are kept but ignored until
            // N new bits have been accepted.
            fill_d  = '0;
            state_d = FILL;
`endif
         end
      end
   end

   // Counter advances on the same edge that registers match.
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (match_d),
      .count (bus.match_count)
   );

   assign bus.match  = match_q;
   assign bus.window = window_q;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: a constant vector table, hand-written
// multi-cycle sequences (gapped valid, reset mid-pattern, saturation) and a
// randomized run checked against a bit-history reference model.
// Two instances share the stimulus: CNT_W=8 and CNT_W=2 (saturation).
module tb_seq_detector;

   localparam int unsigned N   = 4;
   localparam logic [N-1:0] PAT = 4'b1011;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   seq_detector_if #(.N(N), .CNT_W(8)) bus ();
   seq_detector_if #(.N(N), .CNT_W(2)) bus2 ();

   seq_detector #(.N(N), .PATTERN(PAT), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   seq_detector #(.N(N), .PATTERN(PAT), .CNT_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   int ntests = 0;
   int nfail  = 0;

   // Reference model: every accepted bit since reset, plus bits since the
   // last clear (reset, or a match in non-overlapping mode).
   int hist[$];
   int seg  = 0;
   int mcnt = 0;
   bit mexp = 1'b0;

   function automatic logic [N-1:0] model_window();
      logic [N-1:0] w;
      int idx;
      w = '0;
      for (int i = 0; i < int'(N); i++) begin
         idx = hist.size() - int'(N) + i;
         w[int'(N) - 1 - i] = (idx >= 0) ? hist[idx][0] : 1'b0;
      end
      return w;
   endfunction

   task automatic model_step(input logic r, input logic v, input logic d);
      if (r) begin
         hist.delete();
         seg  = 0;
         mcnt = 0;
         mexp = 1'b0;
      end else if (v) begin
         hist.push_back(int'(d));
         seg++;
         if (seg >= int'(N) && model_window() == PAT) begin
            mexp = 1'b1;
            mcnt++;
`ifndef SEQ_OVERLAP_EN
            seg = 0;
`endif
         end else begin
            mexp = 1'b0;
         end
      end else begin
         mexp = 1'b0;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      ntests++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one edge, then sample #1 after it and advance the model.
   task automatic apply(input logic r, input logic v, input logic d);
      rst           = r;
      bus.din       = d;
      bus.din_valid = v;
      bus2.din      = d;
      bus2.din_valid = v;
      @(posedge clk);
      #1;
      model_step(r, v, d);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".match"},  int'(bus.match),        int'(mexp));
      chk({tag, ".count"},  int'(bus.match_count),  (mcnt > 255) ? 255 : mcnt);
      chk({tag, ".window"}, int'(bus.window),       int'(model_window()));
      chk({tag, ".match2"}, int'(bus2.match),       int'(mexp));
      chk({tag, ".count2"}, int'(bus2.match_count), (mcnt > 3) ? 3 : mcnt);
   endtask

   typedef struct {
      logic         r;
      logic         v;
      logic         d;
      logic         em;
      int           ec;
      logic [N-1:0] ew;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic v, input logic d,
                      input logic em, input int ec, input logic [N-1:0] ew);
      vec_t e;
      e.r = r; e.v = v; e.d = d; e.em = em; e.ec = ec; e.ew = ew;
      tbl.push_back(e);
   endtask

   initial begin
      int pulses;
      logic r, v, d;

      bus.din = 1'b0;  bus.din_valid = 1'b0;
      bus2.din = 1'b0; bus2.din_valid = 1'b0;

      // Reset with valid ones, then stream 1,0,1,1,0,1,1 and one idle cycle.
      add(1, 1, 1, 0, 0, 4'b0000);
      add(1, 1, 1, 0, 0, 4'b0000);
      add(0, 1, 1, 0, 0, 4'b0001);
      add(0, 1, 0, 0, 0, 4'b0010);
      add(0, 1, 1, 0, 0, 4'b0101);
      add(0, 1, 1, 1, 1, 4'b1011);
      add(0, 1, 0, 0, 1, 4'b0110);
      add(0, 1, 1, 0, 1, 4'b1101);
`ifdef SEQ_OVERLAP_EN
      add(0, 1, 1, 1, 2, 4'b1011);
      add(0, 0, 0, 0, 2, 4'b1011);
`else
      add(0, 1, 1, 0, 1, 4'b1011);
      add(0, 0, 0, 0, 1, 4'b1011);
`endif
      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d.match", i),  int'(bus.match),       int'(tbl[i].em));
         chk($sformatf("tbl%0d.count", i),  int'(bus.match_count), tbl[i].ec);
         chk($sformatf("tbl%0d.window", i), int'(bus.window),      int'(tbl[i].ew));
      end

      // Gapped valid: 1,0,1,1 with three idle cycles between bits.
      apply(1, 0, 0);
      pulses = 0;
      for (int b = 0; b < 4; b++) begin
         apply(0, 1, PAT[3 - b]);
         check_model("gap");
         pulses += int'(bus.match);
         if (b == 3) chk("gap.final_match", int'(bus.match), 1);
         if (b < 3) begin
            for (int g = 0; g < 3; g++) begin
               apply(0, 0, 1'b1);
               check_model("gap.idle");
               pulses += int'(bus.match);
            end
         end
      end
      chk("gap.pulses", pulses, 1);
      chk("gap.window", int'(bus.window), int'(PAT));

      // Reset mid-pattern: 1,0,1, reset with a valid 1, then 1,0,1,1.
      apply(1, 0, 0);
      pulses = 0;
      apply(0, 1, 1); apply(0, 1, 0); apply(0, 1, 1);
      pulses += int'(bus.match);
      apply(1, 1, 1);
      chk("midrst.window", int'(bus.window), 0);
      chk("midrst.count",  int'(bus.match_count), 0);
      for (int b = 0; b < 4; b++) begin
         apply(0, 1, PAT[3 - b]);
         check_model("midrst");
         pulses += int'(bus.match);
         if (b < 3) chk("midrst.early_match", int'(bus.match), 0);
      end
      chk("midrst.final_match", int'(bus.match), 1);
      chk("midrst.pulses", pulses, 1);

      // Saturation: five back-to-back 1011 patterns.
      apply(1, 0, 0);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         for (int b = 0; b < 4; b++) begin
            apply(0, 1, PAT[3 - b]);
            check_model("sat");
            pulses += int'(bus2.match);
         end
      end
      chk("sat.pulses",  pulses, 5);
      chk("sat.count8",  int'(bus.match_count), 5);
      chk("sat.count2",  int'(bus2.match_count), 3);

      // Randomized traffic against the model.
      apply(1, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 99) == 0);
         v = ($urandom_range(0, 3) != 0);
         d = 1'($urandom_range(0, 1));
         apply(r, v, d);
         check_model("rand");
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
